// File: rtl/registers.sv
// General-purpose register file: 2**ADDR_WIDTH registers of DATA_WIDTH bits.
// Two independent combinational read ports (A, B) and one synchronous
// write port (C). Register 0 is hardwired to zero. The reset is synchronous
// and active-low, and it takes priority over a write on the same edge.
module registers #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ena,
   input  logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dataa,
   input  logic                  enb,
   input  logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] datab,
   input  logic                  enc,
   input  logic [ADDR_WIDTH-1:0] addrc,
   input  logic [DATA_WIDTH-1:0] datac
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regsQ [DEPTH];
   logic [DATA_WIDTH-1:0] regsD [DEPTH];

   logic writeHit;

   // A write only lands when it is enabled and does not target register 0.
   always_comb begin
      writeHit = enc && (addrc != '0);
   end

   // Next-state view of the array: hold every entry, then overlay the write.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regsD[i] = regsQ[i];
      end
      if (writeHit) begin
         regsD[addrc] = datac;
      end
   end

   // Storage update: the synchronous reset clears everything and wins over a write.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regsQ[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regsQ[i] <= regsD[i];
         end
      end
   end

   // Port A read: zero when disabled or when addressing register 0. There is no write bypass.
   always_comb begin
      dataa = '0;
      if (ena && (addra != '0)) begin
         dataa = regsQ[addra];
      end
   end

   // Port B read: the same behaviour as port A, fully independent of it.
   always_comb begin
      datab = '0;
      if (enb && (addrb != '0)) begin
         datab = regsQ[addrb];
      end
   end

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the registers block. Expected read values are
// pushed to scoreboard queues when the read stimulus is driven and popped
// when the combinational outputs are sampled.
module tb_registers;

   logic        clock;
   logic        reset;
   logic        ena;
   logic [4:0]  addra;
   logic [31:0] dataa;
   logic        enb;
   logic [4:0]  addrb;
   logic [31:0] datab;
   logic        enc;
   logic [4:0]  addrc;
   logic [31:0] datac;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model [32];
   logic [31:0] expAQ [$];
   logic [31:0] expBQ [$];
   logic [31:0] expA;
   logic [31:0] expB;

   registers #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clock(clock), .reset(reset),
      .ena(ena), .addra(addra), .dataa(dataa),
      .enb(enb), .addrb(addrb), .datab(datab),
      .enc(enc), .addrc(addrc), .datac(datac)
   );

   // 10 time-unit clock period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected read value from the reference model.
   function automatic logic [31:0] modelRead(input logic en, input logic [4:0] addr);
      if (!en || addr == 5'd0) return 32'h0;
      return model[addr];
   endfunction

   // Updates the model from the current inputs, then advances one rising edge.
   task automatic clockEdge();
      if (!reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (enc && addrc != 5'd0) begin
         model[addrc] = datac;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clockEdge();
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ena = 1'b1; addra = 5'(i);
         enb = 1'b1; addrb = 5'(31 - i);
         expAQ.push_back(32'h0);
         expBQ.push_back(32'h0);
         #1;
         expA = expAQ.pop_front();
         expB = expBQ.pop_front();
         checks += 2;
         if (dataa !== expA) begin
            failures++;
            $display("[TB] FAIL reset_a addr=%0d got=%h exp=%h", i, dataa, expA);
         end
         if (datab !== expB) begin
            failures++;
            $display("[TB] FAIL reset_b addr=%0d got=%h exp=%h", 31 - i, datab, expB);
         end
      end
   endtask

   task automatic test_disabled_write();
      enc = 1'b0; addrc = 5'd11; datac = 32'd45;
      clockEdge();
      enb = 1'b1; addrb = 5'd11;
      expBQ.push_back(32'd0);
      #1;
      expB = expBQ.pop_front();
      checks++;
      if (datab !== expB) begin
         failures++;
         $display("[TB] FAIL disabled_write got=%h exp=%h", datab, expB);
      end
   endtask

   task automatic test_enabled_writes();
      enc = 1'b1; addrc = 5'd11; datac = 32'd45;
      clockEdge();
      enc = 1'b1; addrc = 5'd12; datac = 32'd75;
      clockEdge();
      enc = 1'b0;
      ena = 1'b1; addra = 5'd11;
      enb = 1'b1; addrb = 5'd12;
      expAQ.push_back(32'd45);
      expBQ.push_back(32'd75);
      #1;
      expA = expAQ.pop_front();
      expB = expBQ.pop_front();
      checks += 2;
      if (dataa !== expA) begin
         failures++;
         $display("[TB] FAIL enabled_write_a got=%h exp=%h", dataa, expA);
      end
      if (datab !== expB) begin
         failures++;
         $display("[TB] FAIL enabled_write_b got=%h exp=%h", datab, expB);
      end
   endtask

   task automatic test_read_enables();
      ena = 1'b0; addra = 5'd11;
      enb = 1'b0; addrb = 5'd12;
      expAQ.push_back(32'd0);
      expBQ.push_back(32'd0);
      #1;
      expA = expAQ.pop_front();
      expB = expBQ.pop_front();
      checks += 2;
      if (dataa !== expA) begin
         failures++;
         $display("[TB] FAIL enable_low_a got=%h exp=%h", dataa, expA);
      end
      if (datab !== expB) begin
         failures++;
         $display("[TB] FAIL enable_low_b got=%h exp=%h", datab, expB);
      end
      ena = 1'b1;
      enb = 1'b1;
      expAQ.push_back(32'd45);
      expBQ.push_back(32'd75);
      #1;
      expA = expAQ.pop_front();
      expB = expBQ.pop_front();
      checks += 2;
      if (dataa !== expA) begin
         failures++;
         $display("[TB] FAIL enable_high_a got=%h exp=%h", dataa, expA);
      end
      if (datab !== expB) begin
         failures++;
         $display("[TB] FAIL enable_high_b got=%h exp=%h", datab, expB);
      end
   endtask

   task automatic test_reset_over_write();
      reset = 1'b0;
      enc = 1'b1; addrc = 5'd5; datac = 32'd9;
      clockEdge();
      reset = 1'b1;
      enc = 1'b0;
      enb = 1'b1; addrb = 5'd5;
      for (int i = 0; i < 32; i++) begin
         ena = 1'b1; addra = 5'(i);
         expAQ.push_back(32'h0);
         expBQ.push_back(32'h0);
         #1;
         expA = expAQ.pop_front();
         expB = expBQ.pop_front();
         checks += 2;
         if (dataa !== expA) begin
            failures++;
            $display("[TB] FAIL reset_clear_a addr=%0d got=%h exp=%h", i, dataa, expA);
         end
         if (datab !== expB) begin
            failures++;
            $display("[TB] FAIL reset_beats_write got=%h exp=%h", datab, expB);
         end
      end
   endtask

   task automatic test_reg0();
      enc = 1'b1; addrc = 5'd0; datac = 32'hFFFF_FFFF;
      clockEdge();
      enc = 1'b0;
      ena = 1'b1; addra = 5'd0;
      enb = 1'b1; addrb = 5'd0;
      expAQ.push_back(32'h0);
      expBQ.push_back(32'h0);
      #1;
      expA = expAQ.pop_front();
      expB = expBQ.pop_front();
      checks += 2;
      if (dataa !== expA) begin
         failures++;
         $display("[TB] FAIL reg0_a got=%h exp=%h", dataa, expA);
      end
      if (datab !== expB) begin
         failures++;
         $display("[TB] FAIL reg0_b got=%h exp=%h", datab, expB);
      end
   endtask

   task automatic test_read_during_write();
      enc = 1'b1; addrc = 5'd7; datac = 32'd3;
      clockEdge();
      enc = 1'b1; addrc = 5'd7; datac = 32'd8;
      ena = 1'b1; addra = 5'd7;
      enb = 1'b1; addrb = 5'd7;
      expAQ.push_back(32'd3);
      expBQ.push_back(32'd3);
      #1;
      expA = expAQ.pop_front();
      expB = expBQ.pop_front();
      checks += 2;
      if (dataa !== expA) begin
         failures++;
         $display("[TB] FAIL rdw_before_a got=%h exp=%h", dataa, expA);
      end
      if (datab !== expB) begin
         failures++;
         $display("[TB] FAIL rdw_before_b got=%h exp=%h", datab, expB);
      end
      expAQ.push_back(32'd8);
      expBQ.push_back(32'd8);
      clockEdge();
      enc = 1'b0;
      expA = expAQ.pop_front();
      expB = expBQ.pop_front();
      checks += 2;
      if (dataa !== expA) begin
         failures++;
         $display("[TB] FAIL rdw_after_a got=%h exp=%h", dataa, expA);
      end
      if (datab !== expB) begin
         failures++;
         $display("[TB] FAIL rdw_after_b got=%h exp=%h", datab, expB);
      end
   endtask

   task automatic test_back_to_back();
      ena = 1'b1;
      enb = 1'b1;
      for (int i = 1; i < 32; i++) begin
         enc = 1'b1; addrc = 5'(i); datac = 32'hA500_0000 + 32'(i * 17);
         clockEdge();
         addra = 5'(i);
         addrb = 5'(i - 1);
         expAQ.push_back(32'hA500_0000 + 32'(i * 17));
         expBQ.push_back((i == 1) ? 32'h0 : 32'hA500_0000 + 32'((i - 1) * 17));
         #1;
         expA = expAQ.pop_front();
         expB = expBQ.pop_front();
         checks += 2;
         if (dataa !== expA) begin
            failures++;
            $display("[TB] FAIL b2b_a addr=%0d got=%h exp=%h", i, dataa, expA);
         end
         if (datab !== expB) begin
            failures++;
            $display("[TB] FAIL b2b_b addr=%0d got=%h exp=%h", i - 1, datab, expB);
         end
      end
      enc = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         enc   = 1'($urandom_range(0, 1));
         addrc = 5'($urandom_range(0, 31));
         datac = $urandom;
         ena   = ($urandom_range(0, 7) != 0);
         addra = 5'($urandom_range(0, 31));
         enb   = ($urandom_range(0, 7) != 0);
         addrb = ($urandom_range(0, 3) == 0) ? addra : 5'($urandom_range(0, 31));
         expAQ.push_back(modelRead(ena, addra));
         expBQ.push_back(modelRead(enb, addrb));
         #1;
         expA = expAQ.pop_front();
         expB = expBQ.pop_front();
         checks += 2;
         if (dataa !== expA) begin
            failures++;
            $display("[TB] FAIL random_a n=%0d addr=%0d got=%h exp=%h", n, addra, dataa, expA);
         end
         if (datab !== expB) begin
            failures++;
            $display("[TB] FAIL random_b n=%0d addr=%0d got=%h exp=%h", n, addrb, datab, expB);
         end
         clockEdge();
      end
      enc = 1'b0;
   endtask

   // Main sequence: each scenario drives its own stimulus and checks inline.
   initial begin
      reset = 1'b1;
      ena = 1'b0; addra = '0;
      enb = 1'b0; addrb = '0;
      enc = 1'b0; addrc = '0; datac = '0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      @(negedge clock);
      test_reset();
      test_disabled_write();
      test_enabled_writes();
      test_read_enables();
      test_reset_over_write();
      test_reg0();
      test_read_during_write();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
